fragment_writer: RTL and testbench
==================================

Name: fragment_writer

Overview:
- Consumer end of the rasterizer fragment stream: accepts one fragment (address, color, depth) at a time and stalls the rasterizer while it works.
- Performs a read-compare-write depth test against a Z-buffer in external memory, then writes passing fragments' color and depth.
- Sits between the rasterizer output and the shared memory master port; signals frame completion downstream.

Parameters:
- DEPTH_OFFSET, 26'h004B000, word offset added to frag_addr to form the Z-buffer address (640x480 = 307200 words).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frag_addr  in  26  framebuffer word address of the fragment
- frag_color  in  24  RGB color
- frag_depth  in  32  signed 16.16 depth
- frag_valid  in  1  fragment present
- frag_done  in  1  rasterizer finished the current primitive set
- frag_stall  out  1  back-pressure to the rasterizer's stall input
- depth_test_en  in  1  1 = perform depth test; 0 = always pass with no read
- mem_address  out  26  memory word address
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_writedata  out  32  write data
- mem_readdata  in  32  read data
- mem_readdatavalid  in  1  read data strobe
- mem_waitrequest  in  1  memory busy; the request must be held
- done_out  out  1  one-cycle completion pulse
- frag_written  out  32  count of fragments written
- frag_rejected  out  32  count of fragments failing the depth test

Behaviour:
- Only this block is clocked on clock; everything is synchronous to it.
- Reset (synchronous, active-high) does the following:
  - Sets state to IDLE.
  - Drives mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, done_out=0.
  - Clears frag_written, frag_rejected and done_pending.
  - Aborts any in-flight transaction mid-operation.
  - Ignores a late mem_readdatavalid arriving in IDLE.
- frag_stall is combinational: 1 in any state other than IDLE, and 1 while reset=1.
- Acceptance: a fragment is accepted on a rising edge in IDLE when frag_valid=1. The block latches addr, color and depth.
- States and transitions:
  - IDLE: on accept, go to RD_REQ if depth_test_en=1, else WR_COLOR.
  - RD_REQ: mem_read=1, mem_address=addr+DEPTH_OFFSET. Held until mem_waitrequest=0, then go to RD_WAIT.
  - RD_WAIT: wait for mem_readdatavalid (any latency, including the same cycle the request was accepted; readdatavalid is also sampled in RD_REQ's accepting cycle). On the strobe, compare signed frag_depth < signed mem_readdata:
    - pass: go to WR_COLOR.
    - fail: frag_rejected++ and go to IDLE.
    - Equal depth fails.
  - WR_COLOR: mem_write=1, mem_address=addr, mem_writedata={8'h00,color}. Held until mem_waitrequest=0, then go to WR_DEPTH.
  - WR_DEPTH: mem_write=1, mem_address=addr+DEPTH_OFFSET, mem_writedata=depth. Held until mem_waitrequest=0, then frag_written++ and go to IDLE.
- mem_read and mem_write are never asserted together. The address and data are stable while waitrequest=1.
- Address arithmetic is 26-bit and wraps modulo 2^26. Counters wrap at 2^32.
- Latency with zero wait and read data one cycle after the request: accept at edge 0, RD_REQ at edge 1, data at edge 2, WR_COLOR at edge 3, WR_DEPTH at edge 4, IDLE at edge 5.
- Done handling:
  - frag_done=1 sampled on any edge sets done_pending.
  - done_out pulses for exactly one cycle on the edge where state==IDLE, done_pending=1 and no fragment is accepted that edge; done_pending then clears.
  - If frag_done and frag_valid arrive together, the fragment is processed first and done_out follows after the return to IDLE.
  - Repeated frag_done while pending produces a single pulse.
- frag_valid while stalled is ignored. The rasterizer holds its outputs, so the fragment is accepted on the first IDLE edge.

Test Plan:
- Pass case: depth_test_en=1, memory depth word at 0x4B010 = 0x00050000; fragment addr=0x10, color=0xAABBCC, depth=0x00020000, zero wait, read latency 1 -> read of 0x4B010, then write 0x10←0x00AABBCC, then write 0x4B010←0x00020000; frag_written=1; frag_stall high for 5 cycles.
- Reject case: same setup with depth=0x00050000 (equal) -> exactly one read, no writes, frag_rejected=1, back to IDLE one cycle after readdatavalid.
- Depth test disabled: depth_test_en=0, addr=0x20 -> no read; writes 0x20←{8'h00,color} then 0x4B020←depth; frag_written=1.
- Back-pressure: mem_waitrequest=1 for 3 cycles on each request, read latency 4 -> address and data held constant while waiting; one transaction per state; frag_stall stays 1 throughout; counts correct.
- Done ordering: frag_valid and frag_done asserted on the same cycle -> done_out pulses once, only after the WR_DEPTH completion; a second frag_done while pending -> still a single pulse.
- Reset mid-op: reset in RD_WAIT, then readdatavalid arrives after reset -> mem_read=0, state IDLE, counters 0, no write issued, frag_stall=0 after reset deasserts.

Source files
------------

// File: rtl/fragment_writer.sv
// fragment_writer: consumer end of the rasterizer fragment stream.
// Takes one fragment at a time, optionally performs a read-compare-write
// depth test against a Z-buffer that lives DEPTH_OFFSET words above the
// colour buffer, and writes colour and depth for passing fragments.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   frag_addr/color/depth        fragment payload (depth is signed 16.16)
//   frag_valid, frag_done        fragment present / primitive set finished
//   frag_stall                   back-pressure to the rasterizer
//   depth_test_en                1 = depth test, 0 = unconditional write
//   mem_*                        word-addressed memory master port
//   done_out                     one-cycle completion pulse
//   frag_written, frag_rejected  wrapping fragment counters
module fragment_writer #(
    parameter logic [25:0] DEPTH_OFFSET = 26'h004B000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] frag_addr,
    input  logic [23:0] frag_color,
    input  logic [31:0] frag_depth,
    input  logic        frag_valid,
    input  logic        frag_done,
    output logic        frag_stall,
    input  logic        depth_test_en,
    output logic [25:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    input  logic        mem_waitrequest,
    output logic        done_out,
    output logic [31:0] frag_written,
    output logic [31:0] frag_rejected
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_COLOR, WR_DEPTH} state_t;

    state_t             state;
    state_t             state_next;
    logic [25:0]        addr_q;
    logic [23:0]        color_q;
    logic signed [31:0] depth_q;
    logic               done_pending;
    logic               done_q;
    logic [31:0]        written_q;
    logic [31:0]        rejected_q;

    // Strictly-closer test: an equal depth loses.
    function automatic logic depth_passes(input logic signed [31:0] frag_z,
                                          input logic signed [31:0] stored_z);
        return frag_z < stored_z;
    endfunction

    logic [25:0] z_addr;
    logic        depth_ok;
    logic        read_hit;
    logic        done_fire;

    assign z_addr   = addr_q + DEPTH_OFFSET;
    assign depth_ok = depth_passes(depth_q, $signed(mem_readdata));
    // Read data may come back in the very cycle the request is accepted.
    assign read_hit = mem_readdatavalid &&
                      ((state == RD_WAIT) || (state == RD_REQ && !mem_waitrequest));
    // A fragment accepted on this edge takes priority over the done pulse.
    assign done_fire = done_pending && (state == IDLE) && !frag_valid;

    assign frag_stall    = reset || (state != IDLE);
    assign done_out      = done_q;
    assign frag_written  = written_q;
    assign frag_rejected = rejected_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frag_valid) begin
                    state_next = depth_test_en ? RD_REQ : WR_COLOR;
                end
            end
            RD_REQ: begin
                if (!mem_waitrequest) begin
                    if (mem_readdatavalid) begin
                        state_next = depth_ok ? WR_COLOR : IDLE;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_readdatavalid) begin
                    state_next = depth_ok ? WR_COLOR : IDLE;
                end
            end
            WR_COLOR: begin
                if (!mem_waitrequest) begin
                    state_next = WR_DEPTH;
                end
            end
            WR_DEPTH: begin
                if (!mem_waitrequest) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port outputs: a function of state and the latched fragment only,
    // so address and data cannot move while waitrequest holds a request.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 26'd0;
        mem_writedata = 32'd0;
        case (state)
            RD_REQ: begin
                mem_read    = 1'b1;
                mem_address = z_addr;
            end
            WR_COLOR: begin
                mem_write     = 1'b1;
                mem_address   = addr_q;
                mem_writedata = {8'h00, color_q};
            end
            WR_DEPTH: begin
                mem_write     = 1'b1;
                mem_address   = z_addr;
                mem_writedata = depth_q;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    // Fragment capture at acceptance
    always_ff @(posedge clock) begin
        if (state == IDLE && frag_valid) begin
            addr_q  <= frag_addr;
            color_q <= frag_color;
            depth_q <= frag_depth;
        end
    end

    // Counters and completion handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            written_q    <= 32'd0;
            rejected_q   <= 32'd0;
            done_pending <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= done_fire;
            if (done_fire) begin
                done_pending <= 1'b0;
            end else if (frag_done) begin
                done_pending <= 1'b1;
            end
            if (read_hit && !depth_ok) begin
                rejected_q <= rejected_q + 32'd1;
            end
            if (state == WR_DEPTH && !mem_waitrequest) begin
                written_q <= written_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fragment_writer.sv
module tb_fragment_writer;

    localparam logic [25:0] OFS = 26'h004B000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [25:0] frag_addr = '0;
    logic [23:0] frag_color = '0;
    logic [31:0] frag_depth = '0;
    logic        frag_valid = 1'b0;
    logic        frag_done = 1'b0;
    logic        frag_stall;
    logic        depth_test_en = 1'b0;
    logic [25:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic        mem_waitrequest = 1'b0;
    logic        done_out;
    logic [31:0] frag_written;
    logic [31:0] frag_rejected;

    fragment_writer #(.DEPTH_OFFSET(OFS)) dut (
        .clock(clock), .reset(reset),
        .frag_addr(frag_addr), .frag_color(frag_color), .frag_depth(frag_depth),
        .frag_valid(frag_valid), .frag_done(frag_done), .frag_stall(frag_stall),
        .depth_test_en(depth_test_en),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
        .done_out(done_out), .frag_written(frag_written), .frag_rejected(frag_rejected)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Word memory shared by the responder and the reference model.
    logic [31:0] mem [logic [25:0]];

    // ---------------- memory responder ----------------
    int          fixed_wait = 0;   // -1 = random 0..3
    int          fixed_lat = 1;    // -1 = random 0..4
    int          rd_cnt = 0;
    logic [31:0] rd_data = '0;
    bit          req_seen = 0;
    int          wait_left = 0;

    always @(negedge clock) begin
        int          lat;
        logic [31:0] v;
        mem_readdatavalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = rd_data;
            end
        end
        if (mem_read || mem_write) begin
            if (!req_seen) begin
                req_seen = 1;
                wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
            end else if (wait_left > 0) begin
                wait_left--;
            end
            mem_waitrequest = (wait_left > 0);
            if (!mem_waitrequest) begin
                req_seen = 0;
                if (mem_write) begin
                    mem[mem_address] = mem_writedata;
                end else begin
                    lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
                    v = mem.exists(mem_address) ? mem[mem_address] : 32'h0;
                    if (lat == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata = v;
                    end else begin
                        rd_cnt = lat;
                        rd_data = v;
                    end
                end
            end
        end else begin
            mem_waitrequest = 1'b0;
            req_seen = 0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Each accepted fragment expands into the transactions it must cause.
    typedef struct { int kind; logic [25:0] addr; logic [31:0] data; bit last; bit rej; } ev_t;
    typedef struct { int kind; logic [25:0] addr; logic [31:0] data; int cyc; } log_t;
    localparam int K_READ = 0, K_RDV = 1, K_WRITE = 2;

    ev_t         expq[$];
    log_t        lg[$];
    int          done_cycs[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rdv_cyc = 0;
    int          first_idle_cyc = 0;
    logic [31:0] wcnt = '0;
    logic [31:0] rcnt = '0;
    bit          pend = 0;
    bit          exp_done = 0;
    bit          prev_hold = 0;
    bit          prev_stall = 1;
    logic [59:0] prev_vec = '0;

    always begin
        ev_t         e;
        bit          busy;
        bit          accept;
        bit          fire;
        bit          pass;
        logic [25:0] za;
        @(negedge clock);
        #4;
        cyc++;
        if (reset) begin
            chk("stall_in_reset", frag_stall, 1);
            expq.delete();
            wcnt = '0;
            rcnt = '0;
            pend = 0;
            exp_done = 0;
            prev_hold = 0;
            prev_stall = 1;
        end else begin
            busy = (expq.size() != 0);
            chk("done_out", done_out, exp_done);
            chk("frag_written", frag_written, wcnt);
            chk("frag_rejected", frag_rejected, rcnt);
            chk("frag_stall", frag_stall, busy);
            chk("rd_wr_exclusive", mem_read && mem_write, 0);
            if (prev_hold)
                chk("held_request", {mem_read, mem_write, mem_address, mem_writedata}, prev_vec);
            if (done_out) done_cycs.push_back(cyc);
            if (!frag_stall && prev_stall) first_idle_cyc = cyc;
            prev_stall = frag_stall;

            accept = frag_valid && !busy;
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                lg.push_back('{mem_write ? K_WRITE : K_READ, mem_address, mem_writedata, cyc});
                if (expq.size() == 0 || expq[0].kind != (mem_write ? K_WRITE : K_READ)) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_txn: got %s at 0x%0h, required no such transaction",
                             mem_write ? "write" : "read", mem_address);
                end else begin
                    e = expq.pop_front();
                    chk("txn_addr", mem_address, e.addr);
                    if (mem_write) chk("txn_data", mem_writedata, e.data);
                    if (e.last) wcnt++;
                end
            end
            if (mem_readdatavalid && expq.size() != 0 && expq[0].kind == K_RDV) begin
                e = expq.pop_front();
                rdv_cyc = cyc;
                if (e.rej) rcnt++;
            end

            fire = pend && !busy && !accept;
            exp_done = fire;
            pend = fire ? 1'b0 : (pend | frag_done);

            if (accept) begin
                acc_cyc = cyc;
                za = frag_addr + OFS;
                pass = 1;
                if (depth_test_en) begin
                    if (!mem.exists(za)) mem[za] = $urandom;
                    pass = $signed(frag_depth) < $signed(mem[za]);
                    expq.push_back('{K_READ, za, 32'h0, 0, 0});
                    expq.push_back('{K_RDV, za, 32'h0, 0, !pass});
                end
                if (pass) begin
                    expq.push_back('{K_WRITE, frag_addr, {8'h00, frag_color}, 0, 0});
                    expq.push_back('{K_WRITE, za, frag_depth, 1, 0});
                end
            end
            prev_hold = (mem_read || mem_write) && mem_waitrequest;
            prev_vec = {mem_read, mem_write, mem_address, mem_writedata};
        end
    end

    // ---------------- stimulus helpers (called on a negedge) ----------------
    task automatic send_frag(input logic [25:0] a, input logic [23:0] c,
                             input logic [31:0] d, input bit en, input bit dn);
        bit acc = 0;
        frag_addr = a;
        frag_color = c;
        frag_depth = d;
        depth_test_en = en;
        frag_valid = 1'b1;
        frag_done = dn;
        for (int i = 0; i < 200; i++) begin
            #4;
            acc = !frag_stall && !reset;
            @(negedge clock);
            if (acc) break;
        end
        frag_valid = 1'b0;
        frag_done = 1'b0;
        if (!acc) begin
            n_assert++;
            n_fail++;
            $display("FAIL accept_timeout: fragment 0x%0h not accepted within 200 cycles", a);
        end
    endtask

    task automatic wait_idle(input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc; i++) begin
            #4;
            ok = !frag_stall;
            @(negedge clock);
            if (ok) break;
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL idle_timeout: still stalled after %0d cycles", maxc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_writedata", mem_writedata, 0);
        chk("rst_done_out", done_out, 0);
        chk("rst_written", frag_written, 0);
        chk("rst_stall", frag_stall, 0);

        // Pass case: zero wait, read latency 1
        mem[26'h004B010] = 32'h00050000;
        fixed_wait = 0;
        fixed_lat = 1;
        lg.delete();
        send_frag(26'h10, 24'hAABBCC, 32'h00020000, 1, 0);
        wait_idle(50);
        chk("t1_txn_count", lg.size(), 3);
        if (lg.size() == 3) begin
            chk("t1_rd_addr", lg[0].addr, 26'h004B010);
            chk("t1_rd_edge", lg[0].cyc - acc_cyc, 1);
            chk("t1_rdv_edge", rdv_cyc - acc_cyc, 2);
            chk("t1_wc_addr", lg[1].addr, 26'h10);
            chk("t1_wc_data", lg[1].data, 32'h00AABBCC);
            chk("t1_wc_edge", lg[1].cyc - acc_cyc, 3);
            chk("t1_wd_addr", lg[2].addr, 26'h004B010);
            chk("t1_wd_data", lg[2].data, 32'h00020000);
            chk("t1_wd_edge", lg[2].cyc - acc_cyc, 4);
        end
        chk("t1_idle_edge", first_idle_cyc - acc_cyc, 5);
        chk("t1_written", frag_written, 1);

        // Reject case: equal depth
        mem[26'h004B010] = 32'h00050000;
        lg.delete();
        send_frag(26'h10, 24'hAABBCC, 32'h00050000, 1, 0);
        wait_idle(50);
        chk("t2_txn_count", lg.size(), 1);
        if (lg.size() >= 1) chk("t2_rd_addr", lg[0].addr, 26'h004B010);
        chk("t2_idle_after_rdv", first_idle_cyc - rdv_cyc, 1);
        chk("t2_rejected", frag_rejected, 1);
        chk("t2_written", frag_written, 1);

        // Depth test disabled
        lg.delete();
        send_frag(26'h20, 24'h123456, 32'hFFFF0000, 0, 0);
        wait_idle(50);
        chk("t3_txn_count", lg.size(), 2);
        if (lg.size() == 2) begin
            chk("t3_wc", {lg[0].kind, lg[0].addr, lg[0].data}, {K_WRITE, 26'h20, 32'h00123456});
            chk("t3_wd", {lg[1].kind, lg[1].addr, lg[1].data}, {K_WRITE, 26'h004B020, 32'hFFFF0000});
        end
        chk("t3_written", frag_written, 2);

        // Back-pressure: 3 wait cycles per request, read latency 4, negative depth
        mem[26'h004B030] = 32'h7FFFFFFF;
        fixed_wait = 3;
        fixed_lat = 4;
        lg.delete();
        send_frag(26'h30, 24'h0F0F0F, 32'h80000001, 1, 0);
        wait_idle(100);
        chk("t4_txn_count", lg.size(), 3);
        if (lg.size() == 3) begin
            chk("t4_rd_edge", lg[0].cyc - acc_cyc, 4);
            chk("t4_wc_edge", lg[1].cyc - acc_cyc, 12);
            chk("t4_wd_edge", lg[2].cyc - acc_cyc, 16);
            chk("t4_wd_data", lg[2].data, 32'h80000001);
        end
        chk("t4_idle_edge", first_idle_cyc - acc_cyc, 17);
        chk("t4_written", frag_written, 3);

        // Done ordering: done with the fragment, then again while pending
        fixed_wait = 0;
        fixed_lat = 1;
        lg.delete();
        done_cycs.delete();
        send_frag(26'h40, 24'h010203, 32'h00000100, 0, 1);
        frag_done = 1'b1;
        @(negedge clock);
        frag_done = 1'b0;
        wait_idle(50);
        repeat (6) @(negedge clock);
        chk("t5_done_pulses", done_cycs.size(), 1);
        if (done_cycs.size() == 1 && lg.size() == 2)
            chk("t5_done_after_write", done_cycs[0] - lg[1].cyc, 2);

        // Reset while waiting for read data; data arrives after reset
        fixed_lat = 4;
        mem[26'h004B060] = 32'h00100000;
        lg.delete();
        send_frag(26'h60, 24'hCAFE00, 32'h00010000, 1, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("t6_mem_read", mem_read, 0);
        chk("t6_mem_write", mem_write, 0);
        chk("t6_mem_address", mem_address, 0);
        chk("t6_stall", frag_stall, 0);
        chk("t6_written", frag_written, 0);
        chk("t6_rejected", frag_rejected, 0);
        chk("t6_txn_count", lg.size(), 1);

        // Randomized traffic against the model
        fixed_wait = -1;
        fixed_lat = -1;
        for (int n = 0; n < 250; n++) begin
            logic [25:0] a;
            logic [25:0] za;
            logic [31:0] d;
            bit          en;
            int          gap;
            if ($urandom_range(0, 3) == 0) a = 26'h3FFFFFF - 26'($urandom_range(0, 7));
            else a = 26'($urandom_range(0, 15));
            en = 1'($urandom_range(0, 1));
            za = a + OFS;
            d = $urandom;
            if (en && mem.exists(za) && $urandom_range(0, 3) == 0) d = mem[za];
            send_frag(a, 24'($urandom), d, en, $urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clock);
            if ($urandom_range(0, 15) == 0) begin
                frag_done = 1'b1;
                @(negedge clock);
                frag_done = 1'b0;
            end
        end
        wait_idle(100);
        repeat (5) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
